// File: rtl/serial_adder.sv
// Bit-serial add/subtract: one full-adder slice with a carry flop, LSB first, one bit per clock.
// Results land WIDTH+1 cycles after an accepted start. start is ignored while busy, and a start during done chains directly.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] op_a, op_b, res;
  logic [CW-1:0]    cnt;
  logic             c;
  logic             s, c_nxt, last, accept;

  assign s     = op_a[0] ^ op_b[0] ^ c;
  assign c_nxt = (op_a[0] & op_b[0]) | (op_a[0] & c) | (op_b[0] & c);
  assign last  = (cnt == CW'(WIDTH - 1));

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (last) state_nxt = DONE;
      end
      DONE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = RUN;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_a     <= '0;
      op_b     <= '0;
      res      <= '0;
      cnt      <= '0;
      c        <= 1'b0;
      sum      <= '0;
      cout     <= 1'b0;
      overflow <= 1'b0;
    end else if (accept) begin
      op_a <= a;
      op_b <= sub ? ~b : b;
      c    <= sub ? 1'b1 : cin;
      cnt  <= '0;
    end else if (state == RUN) begin
      op_a <= op_a >> 1;
      op_b <= op_b >> 1;
      res  <= {s, res[WIDTH-1:1]};
      c    <= c_nxt;
      cnt  <= cnt + CW'(1);
      // On the last bit, c is the carry into the MSB, so it directly yields signed overflow.
      if (last) begin
        sum      <= {s, res[WIDTH-1:1]};
        cout     <= c_nxt;
        overflow <= c ^ c_nxt;
      end
    end
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);

endmodule

// File: tb/tb_serial_adder.sv
// Randomised and directed checks of serial_adder against a plain-arithmetic reference model.
module tb_serial_adder;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a = '0, b = '0;
  logic         cin = 1'b0, sub = 1'b0;
  logic         busy, done, cout, overflow;
  logic [W-1:0] sum;

  int n_checks = 0;
  int n_pass   = 0;

  logic [W-1:0] exp_sum  = '0;
  logic         exp_cout = 1'b0;
  logic         exp_ovf  = 1'b0;

  serial_adder #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .cin(cin), .sub(sub),
    .busy(busy), .done(done), .sum(sum), .cout(cout), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] expv);
    n_checks++;
    if (got === expv) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, expv);
  endtask

  // Reference: integer arithmetic on unsigned and signed views of the operands.
  task automatic model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic mc, input logic ms);
    longint ua, ub, sa, sb, u, sr, smax, smin;
    ua = longint'(ma);
    ub = longint'(mb);
    sa = longint'($signed(ma));
    sb = longint'($signed(mb));
    smax = (64'sd1 <<< (W - 1)) - 1;
    smin = -(64'sd1 <<< (W - 1));
    if (ms) begin
      u  = ua - ub;
      sr = sa - sb;
      exp_cout = (ua >= ub);
    end else begin
      u  = ua + ub + longint'(mc);
      sr = sa + sb + longint'(mc);
      exp_cout = (u >= (64'sd1 <<< W));
    end
    exp_sum = u[W-1:0];
    exp_ovf = (sr > smax) || (sr < smin);
  endtask

  task automatic run_op(input string tag, input logic [W-1:0] oa, input logic [W-1:0] ob,
                        input logic oc, input logic os, input bit poke);
    int nb, nd;
    logic [W-1:0] prev_sum;
    prev_sum = exp_sum;
    @(posedge clk); #1;
    start = 1'b1; a = oa; b = ob; cin = oc; sub = os;
    @(posedge clk); #1;
    start = 1'b0;
    a = W'($urandom); b = W'($urandom); cin = 1'($urandom); sub = 1'($urandom);
    model(oa, ob, oc, os);
    nb = 0; nd = 0;
    for (int i = 1; i <= W; i++) begin
      @(negedge clk);
      nb += int'(busy);
      nd += int'(done);
      if (i == W) chk({tag, "_hold_sum"}, sum, prev_sum);
      if (poke && i == 3) begin
        start = 1'b1; a = ~oa; b = oa ^ ob; sub = ~os;
      end
      if (poke && i == 4) start = 1'b0;
    end
    chk({tag, "_busy_cycles"}, nb, W);
    chk({tag, "_done_in_run"}, nd, 0);
    @(negedge clk);
    chk({tag, "_done"}, done, 1'b1);
    chk({tag, "_sum"}, sum, exp_sum);
    chk({tag, "_cout"}, cout, exp_cout);
    chk({tag, "_ovf"}, overflow, exp_ovf);
    @(negedge clk);
    chk({tag, "_done_fall"}, {busy, done}, 2'b00);
  endtask

  task automatic chain(input int n);
    logic [W-1:0] qa[$], qb[$];
    logic         qc[$], qs[$];
    int nb;
    for (int j = 0; j < n; j++) begin
      qa.push_back(W'($urandom)); qb.push_back(W'($urandom));
      qc.push_back(1'($urandom)); qs.push_back(1'($urandom));
    end
    @(posedge clk); #1;
    start = 1'b1; a = qa[0]; b = qb[0]; cin = qc[0]; sub = qs[0];
    @(posedge clk); #1;
    for (int j = 0; j < n; j++) begin
      model(qa[j], qb[j], qc[j], qs[j]);
      if (j < n - 1) begin
        a = qa[j+1]; b = qb[j+1]; cin = qc[j+1]; sub = qs[j+1];
      end else begin
        start = 1'b0;
      end
      nb = 0;
      for (int i = 0; i < W; i++) begin
        @(negedge clk);
        nb += int'(busy);
      end
      chk("chain_busy_cycles", nb, W);
      @(negedge clk);
      chk("chain_done", {busy, done}, 2'b01);
      chk("chain_sum", sum, exp_sum);
      chk("chain_cout", cout, exp_cout);
      chk("chain_ovf", overflow, exp_ovf);
      if (j < n - 1) begin
        @(posedge clk); #1;
      end
    end
    @(negedge clk);
    chk("chain_end_idle", {busy, done}, 2'b00);
  endtask

  initial begin
    int nact;
    #12;
    chk("reset_outputs", {busy, done, cout, overflow, sum}, '0);
    rst_n = 1'b1;

    run_op("add_3c_5a", 8'h3C, 8'h5A, 1'b0, 1'b0, 1'b0);
    chk("t1_sum_const", sum, 8'h96);
    chk("t1_ovf_const", overflow, 1'b1);
    run_op("add_ff_01", 8'hFF, 8'h01, 1'b0, 1'b0, 1'b0);
    run_op("add_cin", 8'h00, 8'h00, 1'b1, 1'b0, 1'b0);
    run_op("sub_10_20", 8'h10, 8'h20, 1'b0, 1'b1, 1'b0);
    chk("t3_sum_const", sum, 8'hF0);
    run_op("sub_80_01", 8'h80, 8'h01, 1'b1, 1'b1, 1'b0);
    run_op("sub_eq", 8'h5A, 8'h5A, 1'b0, 1'b1, 1'b0);
    run_op("poke_mid", 8'h71, 8'h2E, 1'b1, 1'b0, 1'b1);

    chain(6);

    // Abort in the 4th busy cycle.
    run_op("pre_abort", 8'h3C, 8'h5A, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    start = 1'b1; a = 8'h12; b = 8'h34; cin = 1'b0; sub = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_outputs", {busy, done, cout, overflow, sum}, '0);
    #2 rst_n = 1'b1;
    nact = 0;
    repeat (12) begin
      @(negedge clk);
      nact += int'(busy) + int'(done);
    end
    chk("abort_no_done", nact, 0);
    exp_sum = '0;
    run_op("post_abort", 8'hA5, 8'h3B, 1'b1, 1'b0, 1'b0);

    for (int k = 0; k < 20; k++)
      run_op("rand", W'($urandom), W'($urandom), 1'($urandom), 1'($urandom), (k % 5) == 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
Parametrised bit-serial adder/subtractor: the sequential generalisation of the 1-bit half/full adder cell. One full-adder bit slice and a carry flip-flop process a WIDTH-bit operand pair LSB-first, one bit per clock, under a start/busy/done handshake. It adds a carry-in, a subtract mode, carry-out and signed-overflow flags. It targets small-area arithmetic in teaching and datapath examples where latency is traded for a single adder slice.

Parameters:
WIDTH, 8, operand and result width in bits (legal range 2..32)

Ports:
clk  input  1  clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  request new operation; sampled only when not busy
a  input  WIDTH  operand A, captured on accepted start
b  input  WIDTH  operand B, captured on accepted start
cin  input  1  carry-in for add mode; ignored when sub=1
sub  input  1  0 = A+B+cin, 1 = A-B (two's complement), captured on accepted start
busy  output  1  high while bits are being processed
done  output  1  one-cycle pulse when results update
sum  output  WIDTH  result, held stable between completions
cout  output  1  carry-out; in sub mode 1 = no borrow (A >= B unsigned)
overflow  output  1  signed overflow of the last operation

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE; busy=0, done=0, sum=0, cout=0, overflow=0; internal shift registers, carry FF and bit counter cleared. Reset mid-operation aborts it with no done pulse and leaves outputs at 0.
- FSM states: IDLE, RUN, DONE.
- IDLE or DONE with start=1 → RUN:
  - Capture a into opA.
  - Capture b into opB; if sub=1, capture ~b instead.
  - Load carry FF with sub ? 1 : cin.
  - Clear bit counter.
- IDLE with start=0 stays IDLE. DONE with start=0 → IDLE.
- RUN, each cycle:
  - s = opA[0]^opB[0]^c; c_next = majority(opA[0],opB[0],c).
  - Shift opA and opB right by 1.
  - Shift s into the MSB of the internal result shift register.
  - Increment the counter.
  - Before the final bit, record c as carry-into-MSB.
- RUN, when counter = WIDTH-1 (the WIDTH-th bit): on that edge, go to DONE and update the outputs:
  - sum = completed shift register.
  - cout = c_next.
  - overflow = carry-into-MSB XOR c_next.
- busy=1 exactly while state=RUN. done=1 exactly while state=DONE, which is one cycle unless start chains the next operation.
- Latency: start accepted at edge k; busy high for cycles k+1..k+WIDTH; done high and results valid in cycle k+WIDTH+1.
- start while busy is ignored: no re-capture, and the operation in flight is unaffected.
- Back-to-back: start=1 during DONE is accepted, so the next busy immediately follows the done pulse.
- sum, cout and overflow change only on the transition into DONE and hold otherwise. a, b, cin and sub may change freely after capture.
- Arithmetic is modulo 2^WIDTH. No X propagation from unused inputs.

Test Plan:
1. WIDTH=8, add 0x3C+0x5A, cin=0 → after 8 busy cycles, done pulse; sum=0x96, cout=0, overflow=1.
2. Add 0xFF+0x01, cin=0 → sum=0x00, cout=1, overflow=0. Add 0x00+0x00, cin=1 → sum=0x01, cout=0.
3. sub=1: 0x10-0x20 → sum=0xF0, cout=0, overflow=0. Then 0x80-0x01 → sum=0x7F, cout=1, overflow=1.
4. Pulse start with new operands mid-RUN → ignored; result matches the first operands; done asserted exactly once, at k+9.
5. Hold start high continuously with a changing operand stream → done pulses every 9 cycles; each result matches the operands captured at its start.
6. Assert rst_n low at the 4th RUN cycle → outputs immediately 0, state IDLE, no done pulse; the next start completes correctly.
